// File: rtl/mul_pipe_if.sv
// Handshake bundle for mul_pipe_unit: op request, flush, result response and busy status.
interface mul_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/mul_pipe_unit.sv
// Pipelined radix-4 Booth / CSA-tree multiplier for MUL, MULH, MULHSU and MULHU.
// Optional MUL_ZERO_SKIP_EN: zero-operand ops entering an empty pipe bypass to the last stage.
module mul_pipe_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    mul_pipe_if.slave bus
);
    localparam int PW    = 2 * XLEN + 2;
    localparam int BW    = XLEN + 2;
    localparam int NPP   = BW / 2;
    localparam int NROWS = NPP + 1;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] v_q, v_d, en, ld;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [LAST-1:0]   hi_q, hi_d;
    logic [XLEN:0]     a_q, a_d;
    logic [3*NPP-1:0]  dig_q, dig_d;
    logic [XLEN-1:0]   res_q, res_d, res_cpa;
    logic              acc, skip;
    logic              a_sgn, b_sgn;
    logic [BW:0]       bx;
    logic [2:0]        trip;
    logic [PW-1:0]     pp_row [NROWS];
    logic [PW-1:0]     red [NROWS];
    logic [PW-1:0]     nxt [NROWS];
    logic [PW-1:0]     a_sx, mag;
    logic [PW-1:0]     csa_sum, csa_car, cpa_sum, cpa_car, prod;
    logic              unused_prod;
    int                cnt;

    always_comb begin : p_ctrl
        en = '0;
        en[LAST] = !v_q[LAST] || bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end
        acc  = bus.in_valid && !bus.flush && en[0];
        skip = 1'b0;
`ifdef MUL_ZERO_SKIP_EN
        skip = acc && (v_q == '0) && ((bus.in_a == '0) || (bus.in_b == '0));
`endif
        ld    = '0;
        ld[0] = acc && !skip;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = en[k] && v_q[k-1];
        end
        ld[LAST] = ld[LAST] || skip;

        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            if (en[k]) v_d[k] = ld[k];
        end
        if (bus.flush) v_d = '0;

        tag_d[0] = ld[0] ? bus.in_tag : tag_q[0];
        for (int k = 1; k < STAGES; k++) begin
            tag_d[k] = ld[k] ? tag_q[k-1] : tag_q[k];
        end
        if (skip) tag_d[LAST] = bus.in_tag;

        hi_d = hi_q;
        if (ld[0]) hi_d[0] = (bus.in_op != 2'b00);
        for (int k = 1; k < LAST; k++) begin
            if (ld[k]) hi_d[k] = hi_q[k-1];
        end

        res_d = res_q;
        if (ld[LAST]) res_d = skip ? '0 : res_cpa;
    end

    // Extend operands per op signedness and Booth-recode the multiplier into {neg, two, one}.
    always_comb begin : p_recode
        a_sgn = (bus.in_op != 2'b11);
        b_sgn = !bus.in_op[1];
        bx    = {{2{b_sgn & bus.in_b[XLEN-1]}}, bus.in_b, 1'b0};
        trip  = '0;
        a_d   = a_q;
        dig_d = dig_q;
        if (ld[0]) begin
            a_d = {a_sgn & bus.in_a[XLEN-1], bus.in_a};
            for (int i = 0; i < NPP; i++) begin
                trip = bx[2*i +: 3];
                dig_d[3*i]   = trip[1] ^ trip[0];
                dig_d[3*i+1] = (trip == 3'b011) || (trip == 3'b100);
                dig_d[3*i+2] = trip[2] & ~(trip[1] & trip[0]);
            end
        end
    end

    // Negative rows are inverted here; the +1 of each lands in the final correction row.
    always_comb begin : p_ppgen
        a_sx   = {{(PW-XLEN-1){a_q[XLEN]}}, a_q};
        mag    = '0;
        pp_row = '{default: '0};
        for (int i = 0; i < NPP; i++) begin
            mag = '0;
            if (dig_q[3*i]) mag = a_sx;
            else if (dig_q[3*i+1]) mag = a_sx << 1;
            if (dig_q[3*i+2]) mag = ~mag;
            pp_row[i]          = mag << (2 * i);
            pp_row[NPP][2*i]   = dig_q[3*i+2];
        end
    end

    always_comb begin : p_csa
        red = pp_row;
        nxt = '{default: '0};
        cnt = NROWS;
        for (int lvl = 0; lvl < NROWS; lvl++) begin
            if (cnt > 2) begin
                nxt = '{default: '0};
                for (int j = 0; j < NROWS / 3; j++) begin
                    if (j < cnt / 3) begin
                        nxt[2*j]   = red[3*j] ^ red[3*j+1] ^ red[3*j+2];
                        nxt[2*j+1] = ((red[3*j] & red[3*j+1]) | (red[3*j] & red[3*j+2]) |
                                      (red[3*j+1] & red[3*j+2])) << 1;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (r < cnt % 3) nxt[2*(cnt/3)+r] = red[3*(cnt/3)+r];
                end
                red = nxt;
                cnt = 2 * (cnt / 3) + cnt % 3;
            end
        end
        csa_sum = red[0];
        csa_car = red[1];
    end

    if (STAGES == 2) begin : g_no_mid
        assign cpa_sum = csa_sum;
        assign cpa_car = csa_car;
    end else begin : g_mid
        logic [PW-1:0] s1_sum_q, s1_sum_d, s1_car_q, s1_car_d;

        always_comb begin
            s1_sum_d = ld[1] ? csa_sum : s1_sum_q;
            s1_car_d = ld[1] ? csa_car : s1_car_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_sum_q <= '0;
                s1_car_q <= '0;
            end else begin
                s1_sum_q <= s1_sum_d;
                s1_car_q <= s1_car_d;
            end
        end

        if (STAGES == 4) begin : g_mid2
            logic [PW-1:0] s2_sum_q, s2_sum_d, s2_car_q, s2_car_d;

            always_comb begin
                s2_sum_d = ld[2] ? s1_sum_q : s2_sum_q;
                s2_car_d = ld[2] ? s1_car_q : s2_car_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_sum_q <= '0;
                    s2_car_q <= '0;
                end else begin
                    s2_sum_q <= s2_sum_d;
                    s2_car_q <= s2_car_d;
                end
            end

            assign cpa_sum = s2_sum_q;
            assign cpa_car = s2_car_q;
        end else begin : g_mid1
            assign cpa_sum = s1_sum_q;
            assign cpa_car = s1_car_q;
        end
    end

    assign prod        = cpa_sum + cpa_car;
    assign res_cpa     = hi_q[LAST-1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign unused_prod = ^prod[PW-1:2*XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            hi_q  <= '0;
            a_q   <= '0;
            dig_q <= '0;
            res_q <= '0;
            for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
        end else begin
            v_q   <= v_d;
            hi_q  <= hi_d;
            a_q   <= a_d;
            dig_q <= dig_d;
            res_q <= res_d;
            for (int k = 0; k < STAGES; k++) tag_q[k] <= tag_d[k];
        end
    end

    assign bus.in_ready   = !bus.flush && en[0];
    assign bus.out_valid  = v_q[LAST];
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q[LAST];
    assign bus.busy       = |v_q;
endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit (XLEN=32, STAGES=3); latency counts cycles from the accept cycle.
module tb_mul_pipe_unit;
    localparam logic [1:0] OpMul = 2'b00, OpMulh = 2'b01, OpMulhsu = 2'b10, OpMulhu = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mul_pipe_if #(.XLEN(32), .TAG_W(5)) bus ();

    mul_pipe_unit #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [1:0]  s_op  [10] = '{OpMul, OpMul, OpMulhu, OpMul, OpMulh,
                                OpMulh, OpMulhsu, OpMulhu, OpMul, OpMulhsu};
    logic [31:0] s_a   [10] = '{32'h0000FFFF, 32'h00010000, 32'h00010000, 32'hFFFFFFFF,
                                32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'h80000000,
                                32'h12345678, 32'h80000000};
    logic [31:0] s_b   [10] = '{32'h0000FFFF, 32'h00010000, 32'h00010000, 32'hFFFFFFFF,
                                32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000003, 32'h00000004,
                                32'h00000010, 32'hFFFFFFFF};
    logic [31:0] s_exp [10] = '{32'hFFFE0001, 32'h00000000, 32'h00000001, 32'h00000001,
                                32'h3FFFFFFF, 32'hC0000000, 32'hFFFFFFFF, 32'h00000002,
                                32'h23456780, 32'h80000000};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready_seen", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, input logic [31:0] res, input logic [4:0] tag,
                            input int exp_lat, input string name);
        int lat;
        lat = start;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_res"}, 64'(bus.out_result), 64'(res));
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, recv, occ, zlat;
        logic fire_in, fire_out, prev_hold;
        logic [31:0] held_res;
        logic [4:0]  held_tag;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        @(posedge clk);
        #1;
        issue(OpMul, 32'd7, 32'hFFFFFFFD, 5'd9);
        wait_out(1, 32'hFFFFFFEB, 5'd9, 3, "mul_7x-3");
        issue(OpMulh, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        wait_out(1, 32'h00000000, 5'd1, 3, "mulh_ff");
        issue(OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        wait_out(1, 32'hFFFFFFFF, 5'd2, 3, "mulhsu_ff");
        issue(OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        wait_out(1, 32'hFFFFFFFE, 5'd3, 3, "mulhu_ff");
        issue(OpMulh, 32'h80000000, 32'h80000000, 5'd4);
        wait_out(1, 32'h40000000, 5'd4, 3, "mulh_min");
        issue(OpMul, 32'h80000000, 32'h80000000, 5'd5);
        wait_out(1, 32'h00000000, 5'd5, 3, "mul_min");
        chk("idle_after_single", 64'(bus.busy), 64'd0);

        // Streaming with out_ready low for 2 cycles, high for 2 cycles.
        sent = 0;
        recv = 0;
        occ  = 0;
        prev_hold = 1'b0;
        held_res  = '0;
        held_tag  = '0;
        for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
            bus.in_valid = (sent < 10);
            if (sent < 10) begin
                bus.in_op  = s_op[sent];
                bus.in_a   = s_a[sent];
                bus.in_b   = s_b[sent];
                bus.in_tag = 5'(sent + 10);
            end
            bus.out_ready = ((cyc / 2) % 2) == 1;
            @(negedge clk);
            chk("stream_in_ready", 64'(bus.in_ready), 64'((occ < 3) || bus.out_ready));
            if (prev_hold) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_result", 64'(bus.out_result), 64'(held_res));
                chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
            end
            if (bus.out_valid) begin
                if (recv < 10) begin
                    chk("stream_result", 64'(bus.out_result), 64'(s_exp[recv]));
                    chk("stream_tag", 64'(bus.out_tag), 64'(recv + 10));
                end else begin
                    chk("stream_extra_output", 64'd1, 64'd0);
                end
            end
            fire_in   = bus.in_valid && bus.in_ready;
            fire_out  = bus.out_valid && bus.out_ready;
            prev_hold = bus.out_valid && !bus.out_ready;
            held_res  = bus.out_result;
            held_tag  = bus.out_tag;
            @(posedge clk);
            #1;
            if (fire_in) begin
                sent++;
                occ++;
            end
            if (fire_out) begin
                recv++;
                occ--;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", 64'(recv), 64'd10);
        repeat (4) begin
            @(negedge clk);
            chk("stream_no_dup", 64'(bus.out_valid), 64'd0);
        end
        chk("stream_drained", 64'(bus.busy), 64'd0);

        // Zero operand into an empty pipe, then a zero op right behind a non-zero one.
        @(posedge clk);
        #1;
`ifdef MUL_ZERO_SKIP_EN
        zlat = 1;
`else
        zlat = 3;
`endif
        issue(OpMul, 32'h00000000, 32'h00001234, 5'd3);
        wait_out(1, 32'h00000000, 5'd3, zlat, "zero_empty");
        issue(OpMulhu, 32'hFFFFFFFF, 32'h00000000, 5'd6);
        wait_out(1, 32'h00000000, 5'd6, zlat, "zero_b_empty");
        issue(OpMul, 32'd5, 32'd6, 5'd1);
        issue(OpMul, 32'h00000000, 32'h00001234, 5'd2);
        wait_out(2, 32'd30, 5'd1, 3, "b2b_first");
        wait_out(3, 32'h00000000, 5'd2, 3, "b2b_zero_second");

        // Flush with three ops in flight and a concurrent request.
        bus.out_ready = 1'b0;
        issue(OpMul, 32'd2, 32'd3, 5'd20);
        issue(OpMul, 32'd4, 32'd5, 5'd21);
        issue(OpMul, 32'd6, 32'd7, 5'd22);
        chk("full_busy", 64'(bus.busy), 64'd1);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = OpMul;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd9;
        bus.in_tag   = 5'd31;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("flush_no_output", 64'(bus.out_valid), 64'd0);
        end

        // Asynchronous reset with a result presented and another op behind it.
        @(posedge clk);
        #1;
        issue(OpMul, 32'd3, 32'd5, 5'd7);
        issue(OpMul, 32'd8, 32'd8, 5'd8);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_reset_result", 64'(bus.out_result), 64'd15);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_result", 64'(bus.out_result), 64'd0);
        chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        issue(OpMul, 32'd7, 32'hFFFFFFFD, 5'd12);
        wait_out(1, 32'hFFFFFFEB, 5'd12, 3, "post_rst_mul");
        chk("final_idle", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
